i2c_reg_file: RTL

Byte-addressed control/status register file that sits directly downstream of the I2C slave and consumes its register-bus strobes (`reg_addr`, `reg_wdata`, `reg_wr`, `reg_rd`), returning `reg_rdata`. It holds the ID, scratch, control, LED, interrupt and timestamp registers that the STM32 reaches over I2C. It drives board LEDs and a level interrupt back to the MCU.

---
 rtl/i2c_regs_pkg.sv | 38 +++
 rtl/i2c_reg_file_ts_counter.sv | 42 ++++
 rtl/i2c_reg_file.sv | 125 ++++++++++++
 3 files changed

// File: rtl/i2c_regs_pkg.sv
// Register map, CTRL bit positions and reset values shared by the I2C
// control/status register file and its timestamp counter.
package i2c_regs_pkg;

  localparam logic [7:0] DEVICE_ID = 8'hA5;
  localparam logic [7:0] VERSION   = 8'h12;

  localparam logic [7:0] ADDR_ID        = 8'h00;
  localparam logic [7:0] ADDR_VER       = 8'h01;
  localparam logic [7:0] ADDR_SCRATCH   = 8'h02;
  localparam logic [7:0] ADDR_CTRL      = 8'h03;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_IRQ_FLAGS = 8'h05;
  localparam logic [7:0] ADDR_IRQ_MASK  = 8'h06;
  localparam logic [7:0] ADDR_TS0       = 8'h08;
  localparam logic [7:0] ADDR_TS1       = 8'h09;
  localparam logic [7:0] ADDR_TS2       = 8'h0A;
  localparam logic [7:0] ADDR_TS3       = 8'h0B;
  localparam logic [7:0] ADDR_LED       = 8'h10;
  localparam logic [7:0] ADDR_WRCNT     = 8'h20;

  localparam int CTRL_LED_EN   = 0;
  localparam int CTRL_CNT_EN   = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_SOFT_RST = 7;

  localparam logic [7:0] RST_SCRATCH  = 8'h00;
  localparam logic [6:0] RST_CTRL     = 7'h00;
  localparam logic [7:0] RST_IRQ_FLAG = 8'h00;
  localparam logic [7:0] RST_IRQ_MASK = 8'h00;
  localparam logic [7:0] RST_LED      = 8'h00;
  localparam logic [7:0] RST_WRCNT    = 8'h00;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_reg_file_ts_counter.sv
// 32-bit free-running timestamp with enable, synchronous clear and a
// snapshot of the upper three bytes so a multi-byte read is coherent.
module ts_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        snap_i,
  output logic [7:0]  live_o,
  output logic [31:8] shadow_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:8] shadow_q, shadow_d;

  // Snapshot takes the pre-increment value so it matches the TS0 byte read in the same cycle.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (clr_i) begin
      cnt_d    = 32'h0;
      shadow_d = 24'h0;
    end else begin
      if (en_i)   cnt_d    = cnt_q + 32'd1;
      if (snap_i) shadow_d = cnt_q[31:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 32'h0;
      shadow_q <= 24'h0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign live_o   = cnt_q[7:0];
  assign shadow_o = shadow_q;

endmodule

// File: rtl/i2c_reg_file.sv
// Byte-addressed control/status registers behind the I2C slave: ID, scratch,
// control, LED, W1C interrupt flags, timestamp and a saturating write counter.
module i2c_reg_file
  import i2c_regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_wr,
  input  logic       reg_rd,
  output logic [7:0] reg_rdata,
  input  logic [7:0] status_i,
  input  logic [7:0] event_i,
  output logic [7:0] led_o,
  output logic       irq_o
);

  logic [7:0]  scratch_q, scratch_d;
  logic [6:0]  ctrl_q, ctrl_d;
  logic [7:0]  flags_q, flags_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  wrcnt_q, wrcnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        soft_rst;
  logic        ts_snap;
  logic [7:0]  w1c;
  logic [7:0]  ts_live;
  logic [31:8] ts_shadow;

  assign soft_rst = reg_wr && (reg_addr == ADDR_CTRL) && reg_wdata[CTRL_SOFT_RST];
  assign ts_snap  = reg_rd && (reg_addr == ADDR_TS0);
  assign w1c      = (reg_wr && (reg_addr == ADDR_IRQ_FLAGS)) ? reg_wdata : 8'h00;

  // Soft reset overrides every other bit of the same write, including pending events.
  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    flags_d   = flags_q;
    mask_d    = mask_q;
    led_d     = led_q;
    wrcnt_d   = wrcnt_q;
    if (soft_rst) begin
      scratch_d = RST_SCRATCH;
      ctrl_d    = RST_CTRL;
      flags_d   = RST_IRQ_FLAG;
      mask_d    = RST_IRQ_MASK;
      led_d     = RST_LED;
      wrcnt_d   = RST_WRCNT;
    end else begin
      if (reg_wr) begin
        wrcnt_d = sat_inc8(wrcnt_q);
        case (reg_addr)
          ADDR_SCRATCH:  scratch_d = reg_wdata;
          ADDR_CTRL:     ctrl_d    = reg_wdata[6:0];
          ADDR_IRQ_MASK: mask_d    = reg_wdata;
          ADDR_LED:      led_d     = reg_wdata;
          default:       ;
        endcase
      end
      flags_d = (flags_q & ~w1c) | event_i;
    end
  end

  always_comb begin
    rdata_d = 8'h00;
    case (reg_addr)
      ADDR_ID:        rdata_d = DEVICE_ID;
      ADDR_VER:       rdata_d = VERSION;
      ADDR_SCRATCH:   rdata_d = scratch_q;
      ADDR_CTRL:      rdata_d = {1'b0, ctrl_q};
      ADDR_STATUS:    rdata_d = status_i;
      ADDR_IRQ_FLAGS: rdata_d = flags_q;
      ADDR_IRQ_MASK:  rdata_d = mask_q;
      ADDR_TS0:       rdata_d = ts_live;
      ADDR_TS1:       rdata_d = ts_shadow[15:8];
      ADDR_TS2:       rdata_d = ts_shadow[23:16];
      ADDR_TS3:       rdata_d = ts_shadow[31:24];
      ADDR_LED:       rdata_d = led_q;
      ADDR_WRCNT:     rdata_d = wrcnt_q;
      default:        rdata_d = 8'h00;
    endcase
  end

  assign irq_d = ctrl_q[CTRL_IRQ_EN] & (|(flags_q & mask_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= RST_SCRATCH;
      ctrl_q    <= RST_CTRL;
      flags_q   <= RST_IRQ_FLAG;
      mask_q    <= RST_IRQ_MASK;
      led_q     <= RST_LED;
      wrcnt_q   <= RST_WRCNT;
      rdata_q   <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      flags_q   <= flags_d;
      mask_q    <= mask_d;
      led_q     <= led_d;
      wrcnt_q   <= wrcnt_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  ts_counter u_ts (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (ctrl_q[CTRL_CNT_EN]),
    .clr_i    (soft_rst),
    .snap_i   (ts_snap),
    .live_o   (ts_live),
    .shadow_o (ts_shadow)
  );

  assign reg_rdata = rdata_q;
  assign led_o     = ctrl_q[CTRL_LED_EN] ? led_q : 8'h00;
  assign irq_o     = irq_q;

endmodule
